// File: rtl/modulo_condicionador_entradas.sv
// Input conditioner: synchronizes, debounces and edge-detects the operator key,
// the cork-increment key (with auto-repeat) and the start/stop switch.
module modulo_condicionador_entradas #(
  parameter int N_STABLE     = 8,
  parameter int REPEAT_TICKS = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic key_op_n,
  input  logic key_op_c_n,
  input  logic sw_start_stop,
  output logic op_level,
  output logic op_pulse,
  output logic op_c_level,
  output logic op_c_pulse,
  output logic start_stop_db
);

  typedef enum logic [1:0] {RELEASED, DB_PRESS, HELD, DB_RELEASE} state_t;

  localparam int         NCH     = 3;
  localparam logic [3:0] N_LIM   = 4'(N_STABLE);
  localparam logic [7:0] RPT_LIM = 8'(REPEAT_TICKS);
  localparam bit         RPT_EN  = (REPEAT_TICKS != 0);

  // Channels are normalised to active-high so a reset synchronizer reads "inactive".
  logic [NCH-1:0] raw_act;
  logic [NCH-1:0] level_w;
  logic [1:0]     pulse_q;

  assign raw_act = {sw_start_stop, ~key_op_c_n, ~key_op_n};

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    logic       sync1;
    logic       samp;
    state_t     state;
    logic [3:0] cnt;
    logic       level;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sync1 <= 1'b0;
        samp  <= 1'b0;
      end else begin
        sync1 <= raw_act[g];
        samp  <= sync1;
      end
    end

    // Level is updated on the same edge as the state so it never glitches.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state <= RELEASED;
        cnt   <= 4'd0;
        level <= 1'b0;
      end else if (tick) begin
        case (state)
          RELEASED: begin
            if (samp) begin
              state <= DB_PRESS;
              cnt   <= 4'd1;
            end else begin
              cnt <= 4'd0;
            end
          end
          DB_PRESS: begin
            if (!samp) begin
              state <= RELEASED;
              cnt   <= 4'd0;
            end else if (cnt + 4'd1 == N_LIM) begin
              state <= HELD;
              cnt   <= 4'd0;
              level <= 1'b1;
            end else begin
              cnt <= cnt + 4'd1;
            end
          end
          HELD: begin
            if (!samp) begin
              state <= DB_RELEASE;
              cnt   <= 4'd1;
            end
          end
          DB_RELEASE: begin
            if (samp) begin
              state <= HELD;
              cnt   <= 4'd0;
            end else if (cnt + 4'd1 == N_LIM) begin
              state <= RELEASED;
              cnt   <= 4'd0;
              level <= 1'b0;
            end else begin
              cnt <= cnt + 4'd1;
            end
          end
          default: begin
            state <= RELEASED;
            cnt   <= 4'd0;
            level <= 1'b0;
          end
        endcase
      end
    end

    assign level_w[g] = level;

    if (g == 0) begin : g_op
      logic enter_held;
      assign enter_held = tick && samp && (state == DB_PRESS) && (cnt + 4'd1 == N_LIM);

      always_ff @(posedge clk or posedge rst) begin
        if (rst) pulse_q[0] <= 1'b0;
        else     pulse_q[0] <= enter_held;
      end
    end else if (g == 1) begin : g_opc
      logic       enter_held;
      logic       rpt_fire;
      logic [6:0] rpt_cnt;

      assign enter_held = tick && samp && (state == DB_PRESS) && (cnt + 4'd1 == N_LIM);
      // Repeat can only fire from HELD, so it never lands on the press pulse cycle.
      assign rpt_fire   = RPT_EN && tick && samp && (state == HELD) &&
                          ({1'b0, rpt_cnt} + 8'd1 == RPT_LIM);

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          rpt_cnt    <= 7'd0;
          pulse_q[1] <= 1'b0;
        end else begin
          pulse_q[1] <= enter_held | rpt_fire;
          if (state != HELD) begin
            rpt_cnt <= 7'd0;
          end else if (tick) begin
            if (!samp || rpt_fire || !RPT_EN) rpt_cnt <= 7'd0;
            else                              rpt_cnt <= rpt_cnt + 7'd1;
          end
        end
      end
    end
  end

  assign op_level      = level_w[0];
  assign op_c_level    = level_w[1];
  assign start_stop_db = level_w[2];
  assign op_pulse      = pulse_q[0];
  assign op_c_pulse    = pulse_q[1];

endmodule

// File: tb/tb_modulo_condicionador_entradas.sv
// Directed bench for the input conditioner: pulses are checked against the tick
// index at which they are expected, levels are checked at debounce boundaries.
module tb_modulo_condicionador_entradas;

  logic clk = 1'b0;
  logic rst;
  logic tick;
  logic key_op_n;
  logic key_op_c_n;
  logic sw_start_stop;
  logic op_level;
  logic op_pulse;
  logic op_c_level;
  logic op_c_pulse;
  logic start_stop_db;

  int n_cmp    = 0;
  int n_err    = 0;
  int tick_idx = 0;
  bit tick_en  = 1'b0;

  logic [31:0] exp_op_q[$];
  logic [31:0] exp_c_q[$];

  modulo_condicionador_entradas #(
    .N_STABLE    (8),
    .REPEAT_TICKS(64)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .tick         (tick),
    .key_op_n     (key_op_n),
    .key_op_c_n   (key_op_c_n),
    .sw_start_stop(sw_start_stop),
    .op_level     (op_level),
    .op_pulse     (op_pulse),
    .op_c_level   (op_c_level),
    .op_c_pulse   (op_c_pulse),
    .start_stop_db(start_stop_db)
  );

  // Clock / tick generation
  always #5 clk = ~clk;

  initial begin
    int phase;
    phase = 0;
    tick  = 1'b0;
    forever begin
      @(negedge clk);
      tick  = tick_en && (phase == 0);
      phase = (phase + 1) % 4;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      if (tick === 1'b1) tick_idx++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Returns at the falling edge right after the n-th upcoming tick edge.
  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      int guard;
      guard = 0;
      do begin
        @(posedge clk);
        guard++;
      end while (tick !== 1'b1 && guard < 16);
      if (tick !== 1'b1) check("tick_wait", 32'(guard), 32'd0);
      @(negedge clk);
    end
  endtask

  // Scoreboard: each pulse pops the tick index it was expected at.
  initial begin
    logic [31:0] exp;
    forever begin
      @(negedge clk);
      if (op_pulse === 1'b1) begin
        exp = (exp_op_q.size() > 0) ? exp_op_q.pop_front() : 32'hFFFF_FFFF;
        check("op_pulse_tick", 32'(tick_idx), exp);
      end
      if (op_c_pulse === 1'b1) begin
        exp = (exp_c_q.size() > 0) ? exp_c_q.pop_front() : 32'hFFFF_FFFF;
        check("op_c_pulse_tick", 32'(tick_idx), exp);
      end
    end
  end

  initial begin
    int k;
    rst           = 1'b1;
    key_op_n      = 1'b1;
    key_op_c_n    = 1'b1;
    sw_start_stop = 1'b0;
    tick_en       = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_op_level", 32'(op_level), 32'd0);
    check("rst_op_pulse", 32'(op_pulse), 32'd0);
    check("rst_op_c_level", 32'(op_c_level), 32'd0);
    check("rst_op_c_pulse", 32'(op_c_pulse), 32'd0);
    check("rst_start_stop_db", 32'(start_stop_db), 32'd0);
    rst = 1'b0;
    wait_ticks(2);

    // Operator key press: one pulse 8 ticks later, release after 8 more
    key_op_n = 1'b0;
    k = tick_idx;
    exp_op_q.push_back(32'(k + 8));
    wait_ticks(7);
    check("op_level_before_8", 32'(op_level), 32'd0);
    wait_ticks(1);
    check("op_level_at_8", 32'(op_level), 32'd1);
    check("op_pulse_at_8", 32'(op_pulse), 32'd1);
    key_op_n = 1'b1;
    wait_ticks(7);
    check("op_level_release_7", 32'(op_level), 32'd1);
    wait_ticks(1);
    check("op_level_release_8", 32'(op_level), 32'd0);

    // Cork key bouncing every 3 ticks: never debounces
    for (int s = 0; s < 10; s++) begin
      key_op_c_n = s[0];
      wait_ticks(3);
      check("op_c_bounce_level", 32'(op_c_level), 32'd0);
    end
    key_op_c_n = 1'b1;
    wait_ticks(10);
    check("op_c_bounce_settled", 32'(op_c_level), 32'd0);

    // Cork key held ~200 ticks: press pulse + repeats at 64 and 128 ticks
    key_op_c_n = 1'b0;
    k = tick_idx;
    exp_c_q.push_back(32'(k + 8));
    exp_c_q.push_back(32'(k + 8 + 64));
    exp_c_q.push_back(32'(k + 8 + 128));
    wait_ticks(196);
    check("op_c_level_held", 32'(op_c_level), 32'd1);
    key_op_c_n = 1'b1;
    wait_ticks(7);
    check("op_c_level_release_7", 32'(op_c_level), 32'd1);
    wait_ticks(1);
    check("op_c_level_release_8", 32'(op_c_level), 32'd0);

    // Start/stop with a 5-tick glitch after 4 ticks high
    sw_start_stop = 1'b1;
    wait_ticks(4);
    check("ss_before_glitch", 32'(start_stop_db), 32'd0);
    sw_start_stop = 1'b0;
    wait_ticks(5);
    check("ss_after_glitch", 32'(start_stop_db), 32'd0);
    sw_start_stop = 1'b1;
    wait_ticks(7);
    check("ss_high_7", 32'(start_stop_db), 32'd0);
    wait_ticks(1);
    check("ss_high_8", 32'(start_stop_db), 32'd1);
    sw_start_stop = 1'b0;
    wait_ticks(8);
    check("ss_low_8", 32'(start_stop_db), 32'd0);

    // All channels at once, independently
    key_op_n      = 1'b0;
    key_op_c_n    = 1'b0;
    sw_start_stop = 1'b1;
    k = tick_idx;
    exp_op_q.push_back(32'(k + 8));
    exp_c_q.push_back(32'(k + 8));
    wait_ticks(7);
    check("sim_op_7", 32'(op_level), 32'd0);
    check("sim_op_c_7", 32'(op_c_level), 32'd0);
    check("sim_ss_7", 32'(start_stop_db), 32'd0);
    wait_ticks(1);
    check("sim_op_8", 32'(op_level), 32'd1);
    check("sim_op_c_8", 32'(op_c_level), 32'd1);
    check("sim_ss_8", 32'(start_stop_db), 32'd1);
    key_op_n      = 1'b1;
    key_op_c_n    = 1'b1;
    sw_start_stop = 1'b0;
    wait_ticks(8);
    check("sim_op_rel", 32'(op_level), 32'd0);
    check("sim_op_c_rel", 32'(op_c_level), 32'd0);
    check("sim_ss_rel", 32'(start_stop_db), 32'd0);

    // Reset while HELD, key kept pressed: must debounce again
    key_op_n = 1'b0;
    k = tick_idx;
    exp_op_q.push_back(32'(k + 8));
    wait_ticks(9);
    check("op_level_held_pre_rst", 32'(op_level), 32'd1);
    rst = 1'b1;
    #1;
    check("op_level_async_rst", 32'(op_level), 32'd0);
    check("op_pulse_async_rst", 32'(op_pulse), 32'd0);
    wait_ticks(2);
    rst = 1'b0;
    k = tick_idx;
    exp_op_q.push_back(32'(k + 8));
    wait_ticks(7);
    check("op_level_post_rst_7", 32'(op_level), 32'd0);
    wait_ticks(1);
    check("op_level_post_rst_8", 32'(op_level), 32'd1);
    key_op_n = 1'b1;
    wait_ticks(8);
    check("op_level_post_rst_rel", 32'(op_level), 32'd0);

    // No ticks: everything holds at 0 despite pressed inputs
    wait_ticks(1);
    tick_en       = 1'b0;
    key_op_n      = 1'b0;
    key_op_c_n    = 1'b0;
    sw_start_stop = 1'b1;
    for (int j = 0; j < 4; j++) begin
      repeat (250) @(negedge clk);
      check("notick_op_level", 32'(op_level), 32'd0);
      check("notick_op_c_level", 32'(op_c_level), 32'd0);
      check("notick_ss", 32'(start_stop_db), 32'd0);
    end
    key_op_n      = 1'b1;
    key_op_c_n    = 1'b1;
    sw_start_stop = 1'b0;
    repeat (4) @(negedge clk);
    tick_en = 1'b1;
    wait_ticks(10);

    check("op_q_empty", 32'(exp_op_q.size()), 32'd0);
    check("op_c_q_empty", 32'(exp_c_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
